// File: rtl/mem_access_unit_pkg.sv
// Shared types for the data-memory access stage: access kinds, access sizes and FSM states.
// Also holds the byte-swap helper used between the big-endian CPU word and the little-endian bus.
package mem_access_unit_pkg;

   typedef enum logic [2:0] {
      ACC_WORD = 3'd0,
      ACC_HALF = 3'd1,
      ACC_BYTE = 3'd2,
      ACC_LWL  = 3'd3,
      ACC_LWR  = 3'd4
   } access_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } mem_state_t;

   function automatic logic [31:0] byteswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   // Partial-word loads (LWL/LWR) always move the whole word; the merge happens upstream.
   function automatic size_t access_size(input access_t kind);
      case (kind)
         ACC_HALF: return SZ_HALF;
         ACC_BYTE: return SZ_BYTE;
         default:  return SZ_WORD;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU request/response and Avalon-MM master signals of the memory access stage.
// master = the access unit itself, slave = the surrounding CPU pipeline and bus fabric.
interface mem_access_unit_if;
   import mem_access_unit_pkg::*;

   logic        req_valid_i;
   logic        req_write_i;
   access_t     req_kind_i;
   logic [31:0] req_addr_i;
   logic [1:0]  req_offset_i;
   logic [31:0] req_wdata_i;
   logic        ready_o;
   logic        done_o;
   logic        err_o;
   logic [31:0] rdata_o;
   logic [31:0] avm_address_o;
   logic        avm_read_o;
   logic        avm_write_o;
   logic [3:0]  avm_byteenable_o;
   logic [31:0] avm_writedata_o;
   logic [31:0] avm_readdata_i;
   logic        avm_waitrequest_i;

   modport master (
      input  req_valid_i, req_write_i, req_kind_i, req_addr_i, req_offset_i, req_wdata_i,
      input  avm_readdata_i, avm_waitrequest_i,
      output ready_o, done_o, err_o, rdata_o,
      output avm_address_o, avm_read_o, avm_write_o, avm_byteenable_o, avm_writedata_o
   );

   modport slave (
      output req_valid_i, req_write_i, req_kind_i, req_addr_i, req_offset_i, req_wdata_i,
      output avm_readdata_i, avm_waitrequest_i,
      input  ready_o, done_o, err_o, rdata_o,
      input  avm_address_o, avm_read_o, avm_write_o, avm_byteenable_o, avm_writedata_o
   );

endinterface

// File: rtl/mem_lane_map.sv
// Combinational lane mapping: byteenable, endian swap both ways, misalignment / unsupported flags.
// Byteenable bit k selects CPU byte offset k, which after the swap sits on bus bits [8k+7:8k].
module mem_lane_map
   import mem_access_unit_pkg::*;
(
   input  access_t     kind,
   input  logic [1:0]  offset,
   input  logic        write,
   input  logic [31:0] cpu_wdata,
   input  logic [31:0] bus_rdata,
   output logic [3:0]  byteenable,
   output logic [31:0] bus_wdata,
   output logic [31:0] cpu_rdata,
   output logic        misaligned,
   output logic        unsupported
);

   size_t size;

   assign bus_wdata = byteswap32(cpu_wdata);
   assign cpu_rdata = byteswap32(bus_rdata);

   always_comb begin
      size        = access_size(kind);
      misaligned  = 1'b0;
      unsupported = 1'b0;
      byteenable  = 4'b1111;

      case (kind)
         ACC_WORD: misaligned = (offset != 2'd0);
         ACC_HALF: misaligned = offset[0];
         default:  misaligned = 1'b0;
      endcase

      // Loads always fetch the full word; only stores narrow the lanes.
      if (write) begin
         unsupported = (kind == ACC_LWL) || (kind == ACC_LWR);
         case (size)
            SZ_HALF: byteenable = offset[1] ? 4'b1100 : 4'b0011;
            SZ_BYTE: byteenable = 4'b0001 << offset;
            default: byteenable = 4'b1111;
         endcase
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: one Avalon-MM transaction per request, all outputs registered.
// Define MEM_TIMEOUT_EN to abort transactions stalled by waitrequest for TIMEOUT_CYCLES cycles.
module mem_access_unit
   import mem_access_unit_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
)
`endif
(
   input logic               clk,
   input logic               reset_i,
   mem_access_unit_if.master io
);

   mem_state_t  state_q, state_d;
   logic        ready_q, ready_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] addr_q, addr_d;
   logic        read_q, read_d;
   logic        write_q, write_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;

   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;
   logic [31:0] lane_rdata;
   logic        lane_misaligned;
   logic        lane_unsupported;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

   mem_lane_map u_lane_map (
      .kind        (io.req_kind_i),
      .offset      (io.req_offset_i),
      .write       (io.req_write_i),
      .cpu_wdata   (io.req_wdata_i),
      .bus_rdata   (io.avm_readdata_i),
      .byteenable  (lane_be),
      .bus_wdata   (lane_wdata),
      .cpu_rdata   (lane_rdata),
      .misaligned  (lane_misaligned),
      .unsupported (lane_unsupported)
   );

   always_comb begin
      state_d = state_q;
      ready_d = ready_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      rdata_d = rdata_q;
      addr_d  = addr_q;
      read_d  = read_q;
      write_d = write_q;
      be_d    = be_q;
      wdata_d = wdata_q;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_d = wait_cnt_q;
`endif

      unique case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (ready_q && io.req_valid_i) begin
               ready_d = 1'b0;
               if (lane_misaligned || lane_unsupported) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  addr_d  = io.req_addr_i & ~32'h3;
                  be_d    = lane_be;
                  wdata_d = lane_wdata;
                  read_d  = ~io.req_write_i;
                  write_d = io.req_write_i;
                  state_d = io.req_write_i ? WRITE : READ;
`ifdef MEM_TIMEOUT_EN
                  wait_cnt_d = '0;
`endif
               end
            end
         end

         READ, WRITE: begin
            if (!io.avm_waitrequest_i) begin
               read_d  = 1'b0;
               write_d = 1'b0;
               state_d = DONE;
               done_d  = 1'b1;
               if (state_q == READ) rdata_d = lane_rdata;
            end
`ifdef MEM_TIMEOUT_EN
            else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               // This stalled cycle is the TIMEOUT_CYCLES-th one: give up the bus.
               read_d  = 1'b0;
               write_d = 1'b0;
               state_d = DONE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
`endif
         end

         DONE: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         addr_q  <= '0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
         wait_cnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         addr_q  <= addr_d;
         read_q  <= read_d;
         write_q <= write_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
`ifdef MEM_TIMEOUT_EN
         wait_cnt_q <= wait_cnt_d;
`endif
      end
   end

   assign io.ready_o          = ready_q;
   assign io.done_o           = done_q;
   assign io.err_o            = err_q;
   assign io.rdata_o          = rdata_q;
   assign io.avm_address_o    = addr_q;
   assign io.avm_read_o       = read_q;
   assign io.avm_write_o      = write_q;
   assign io.avm_byteenable_o = be_q;
   assign io.avm_writedata_o  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a byte-level reference model.
// Build with MEM_TIMEOUT_EN defined to exercise the waitrequest timeout abort.
`timescale 1ns/1ps
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   localparam int TMO = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_access_unit_if io();

`ifdef MEM_TIMEOUT_EN
   mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .reset_i(reset), .io(io));
`else
   mem_access_unit dut (.clk(clk), .reset_i(reset), .io(io));
`endif

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] model_rdata;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: CPU byte offset k lives in bits [31-8k -: 8], bus byte k in [8k +: 8].
   function automatic logic [31:0] to_bus_order(input logic [31:0] w);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[8*k +: 8] = w[8*(3-k) +: 8];
      return r;
   endfunction

   function automatic logic [3:0] model_be(input access_t kind, input logic wr, input logic [1:0] off);
      logic [3:0] be;
      be = 4'b0000;
      if (!wr || kind == ACC_WORD) be = 4'b1111;
      else if (kind == ACC_HALF) begin
         be[off] = 1'b1;
         be[off + 2'd1] = 1'b1;
      end else be[off] = 1'b1;
      return be;
   endfunction

   function automatic bit model_fault(input access_t kind, input logic wr, input logic [1:0] off);
      if (kind == ACC_WORD && off != 2'd0) return 1'b1;
      if (kind == ACC_HALF && (off == 2'd1 || off == 2'd3)) return 1'b1;
      if (wr && (kind == ACC_LWL || kind == ACC_LWR)) return 1'b1;
      return 1'b0;
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (io.ready_o !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("ready_wait", 32'(io.ready_o), 32'd1);
   endtask

   // Issues one request and checks every cycle up to the return to IDLE.
   task automatic run_txn(input access_t kind, input logic wr, input logic [31:0] addr,
                          input logic [1:0] off, input logic [31:0] wd, input logic [31:0] rd,
                          input int nwait, input bit stuck);
      int ncyc;
      bit wreq;
      wait_ready();
      io.req_valid_i  = 1'b1;
      io.req_write_i  = wr;
      io.req_kind_i   = kind;
      io.req_addr_i   = addr;
      io.req_offset_i = off;
      io.req_wdata_i  = wd;
      @(posedge clk); #1;

      if (model_fault(kind, wr, off)) begin
         check("flt_done", 32'(io.done_o), 32'd1);
         check("flt_err", 32'(io.err_o), 32'd1);
         check("flt_strobes", 32'({io.avm_read_o, io.avm_write_o}), 32'd0);
         check("flt_rdata", io.rdata_o, model_rdata);
         io.req_valid_i = 1'b0;
         @(posedge clk); #1;
         check("flt_done_pulse", 32'(io.done_o), 32'd0);
         check("flt_ready", 32'(io.ready_o), 32'd1);
         return;
      end

      ncyc = stuck ? TMO : nwait + 1;
      for (int c = 0; c < ncyc; c++) begin
         wreq = stuck || (c < nwait);
         io.avm_waitrequest_i = wreq;
         io.avm_readdata_i    = wreq ? $urandom : rd;
         check("strobe", 32'({io.avm_read_o, io.avm_write_o}), 32'({~wr, wr}));
         check("address", io.avm_address_o, {addr[31:2], 2'b00});
         check("byteenable", 32'(io.avm_byteenable_o), 32'(model_be(kind, wr, off)));
         if (wr) check("writedata", io.avm_writedata_o, to_bus_order(wd));
         check("early_done", 32'(io.done_o), 32'd0);
         @(posedge clk); #1;
      end
      io.avm_waitrequest_i = 1'b0;
      if (!wr && !stuck) model_rdata = to_bus_order(rd);
      check("done", 32'(io.done_o), 32'd1);
      check("err", 32'(io.err_o), 32'(stuck));
      check("strobe_drop", 32'({io.avm_read_o, io.avm_write_o}), 32'd0);
      check("rdata", io.rdata_o, model_rdata);
      check("busy_ready", 32'(io.ready_o), 32'd0);
      io.req_valid_i = 1'b0;
      @(posedge clk); #1;
      check("done_pulse", 32'(io.done_o), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      io.req_valid_i = 1'b0;
      io.req_write_i = 1'b0;
      io.req_kind_i = ACC_WORD;
      io.req_addr_i = '0;
      io.req_offset_i = '0;
      io.req_wdata_i = '0;
      io.avm_readdata_i = '0;
      io.avm_waitrequest_i = 1'b0;
      model_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(io.ready_o), 32'd0);
      check("rst_done_err", 32'({io.done_o, io.err_o}), 32'd0);
      check("rst_strobes", 32'({io.avm_read_o, io.avm_write_o}), 32'd0);
      check("rst_rdata", io.rdata_o, 32'd0);
      check("rst_bus", io.avm_address_o | io.avm_writedata_o | 32'(io.avm_byteenable_o), 32'd0);
      reset = 1'b0;

      // Directed cases from the feature list.
      run_txn(ACC_WORD, 1'b0, 32'h0000_1000, 2'd0, 32'h0, 32'h4433_2211, 0, 1'b0);
      check("load_word_rdata", io.rdata_o, 32'h1122_3344);
      run_txn(ACC_BYTE, 1'b1, 32'h0000_2004, 2'd2, 32'h0000_AB00, 32'h0, 3, 1'b0);
      run_txn(ACC_HALF, 1'b1, 32'h0000_3008, 2'd2, 32'h0000_BEEF, 32'h0, 0, 1'b0);
      run_txn(ACC_HALF, 1'b0, 32'h0000_4000, 2'd1, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
      run_txn(ACC_LWL,  1'b1, 32'h0000_5000, 2'd1, 32'h1234_5678, 32'h0, 0, 1'b0);
      run_txn(ACC_LWR,  1'b0, 32'h0000_6000, 2'd3, 32'h0, 32'hA1B2_C3D4, 1, 1'b0);

      // Reset while a read is stalled.
      wait_ready();
      io.req_valid_i = 1'b1;
      io.req_write_i = 1'b0;
      io.req_kind_i = ACC_WORD;
      io.req_addr_i = 32'h0000_7000;
      io.req_offset_i = 2'd0;
      io.avm_waitrequest_i = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_strobe", 32'(io.avm_read_o), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      io.req_valid_i = 1'b0;
      @(posedge clk); #1;
      model_rdata = '0;
      check("rst_mid_read", 32'(io.avm_read_o), 32'd0);
      check("rst_mid_done", 32'(io.done_o), 32'd0);
      check("rst_mid_ready", 32'(io.ready_o), 32'd0);
      reset = 1'b0;
      io.avm_waitrequest_i = 1'b0;
      @(posedge clk); #1;
      check("rst_rel_done", 32'(io.done_o), 32'd0);
      check("rst_rel_ready", 32'(io.ready_o), 32'd1);

`ifdef MEM_TIMEOUT_EN
      run_txn(ACC_WORD, 1'b0, 32'h0000_8000, 2'd0, 32'h0, 32'h0, 0, 1'b1);
      run_txn(ACC_BYTE, 1'b1, 32'h0000_8004, 2'd3, 32'h0000_00C5, 32'h0, 0, 1'b1);
`endif

      for (int i = 0; i < 40; i++) begin
         run_txn(access_t'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                 $urandom & 32'hFFFF_FFFC, 2'($urandom_range(0, 3)), $urandom, $urandom,
                 $urandom_range(0, 3), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
